multi_debouncer: RTL



---
 rtl/multi_debouncer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debouncer
//  Description : N-channel push-button debouncer. Each channel has a 2-flop
//                synchroniser, a stability counter, a debounced level and
//                registered one-cycle press / release pulses.
//                Optional auto-repeat of press on held buttons is enabled by
//                defining the macro DEBOUNCE_AUTOREPEAT_EN.
//                The release pulse port is named release_pulse because
//                "release" is a reserved word in SystemVerilog.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse
);

    localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] c_ST_LOW  = 1'b0;
    localparam logic [0:0] c_ST_HIGH = 1'b1;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    // Two-flop synchroniser; nothing downstream looks at btn directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [0:0]         r_state;
            logic [0:0]         w_state_nxt;
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_CNT_W-1:0] w_cnt_nxt;
            logic               w_rise;
            logic               w_fall;
            logic               w_repeat;
            logic               r_press;
            logic               r_rel;

            // Level FSM next state: count consecutive differing samples and
            // flip once STABLE_CYCLES of them have been seen in a row.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = '0;
                w_rise      = 1'b0;
                w_fall      = 1'b0;
                case (r_state)
                    c_ST_LOW: begin
                        if (r_sync2[i]) begin
                            if (r_cnt == c_CNT_LAST) begin
                                w_state_nxt = c_ST_HIGH;
                                w_rise      = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + 1'b1;
                            end
                        end
                    end
                    c_ST_HIGH: begin
                        if (!r_sync2[i]) begin
                            if (r_cnt == c_CNT_LAST) begin
                                w_state_nxt = c_ST_LOW;
                                w_fall      = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + 1'b1;
                            end
                        end
                    end
                    default: w_state_nxt = c_ST_LOW;
                endcase
            end

            // State, counter and registered event pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= c_ST_LOW;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_press <= w_rise | w_repeat;
                    r_rel   <= w_fall;
                end
            end

`ifdef DEBOUNCE_AUTOREPEAT_EN
            localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                        REPEAT_DELAY : REPEAT_PERIOD;
            localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
            localparam logic [c_HOLD_W-1:0] c_DELAY_LAST  = c_HOLD_W'(REPEAT_DELAY - 1);
            localparam logic [c_HOLD_W-1:0] c_PERIOD_LAST = c_HOLD_W'(REPEAT_PERIOD - 1);

            logic [c_HOLD_W-1:0] r_hold;
            logic [c_HOLD_W-1:0] w_hold_nxt;
            logic                r_phase;
            logic                w_phase_nxt;

            // Hold timer: first wait REPEAT_DELAY, then REPEAT_PERIOD between
            // repeats. Held at zero outside HIGH and on the release edge, so
            // a repeat can never coincide with release.
            always_comb begin
                w_hold_nxt  = '0;
                w_phase_nxt = 1'b0;
                w_repeat    = 1'b0;
                if ((r_state == c_ST_HIGH) && !w_fall) begin
                    w_phase_nxt = r_phase;
                    if (r_hold == (r_phase ? c_PERIOD_LAST : c_DELAY_LAST)) begin
                        w_repeat    = 1'b1;
                        w_hold_nxt  = '0;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end

            // Hold timer registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold  <= '0;
                    r_phase <= 1'b0;
                end else begin
                    r_hold  <= w_hold_nxt;
                    r_phase <= w_phase_nxt;
                end
            end
`else
            assign w_repeat = 1'b0;
`endif

            assign level[i]         = r_state[0];
            assign press[i]         = r_press;
            assign release_pulse[i] = r_rel;
        end
    endgenerate

endmodule
`default_nettype wire
